// File: rtl/alu_arbiter.sv
// Two-requester front end for one registered ALU: grant, issue, capture, respond.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int Width = 8
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    input  logic [1:0]           Valid_i,
    input  logic [3:0]           Opc_i,
    input  logic [2*Width-1:0]   DinA_i,
    input  logic [2*Width-1:0]   DinB_i,
    output logic [1:0]           Accept_o,
    output logic [1:0]           AluOpc_o,
    output logic [Width-1:0]     AluDinA_o,
    output logic [Width-1:0]     AluDinB_o,
    input  logic [Width-1:0]     AluDout_i,
    input  logic                 AluOverFlow_i,
    output logic                 RspValid_o,
    input  logic                 RspReady_i,
    output logic                 RspId_o,
    output logic [Width-1:0]     RspDout_o,
    output logic                 RspOverFlow_o,
    output logic                 Busy_o,
    output logic [1:0]           DbgState_o
);

    // Handshakes: a request transfers on a rising edge where Valid_i[r] && Accept_o[r];
    // a response transfers on a rising edge where RspValid_o && RspReady_i.
    // Requesters hold Valid_i and their operand slices stable until accepted.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state;
    logic   grant;
    logic   any_valid;

`ifdef ALU_ARB_RR_EN
    logic last;
`endif

    always_comb begin
        any_valid = |Valid_i;
`ifdef ALU_ARB_RR_EN
        // A tie goes to whoever was not served last; a lone request wins outright.
        if (&Valid_i) grant = ~last;
        else          grant = ~Valid_i[0];
`else
        grant = ~Valid_i[0];
`endif
        Accept_o = 2'b00;
        if (state == IDLE && any_valid) Accept_o = grant ? 2'b10 : 2'b01;
    end

    assign DbgState_o = state;

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state         <= IDLE;
            AluOpc_o      <= '0;
            AluDinA_o     <= '0;
            AluDinB_o     <= '0;
            RspValid_o    <= 1'b0;
            RspId_o       <= 1'b0;
            RspDout_o     <= '0;
            RspOverFlow_o <= 1'b0;
            Busy_o        <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last          <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        AluOpc_o  <= grant ? Opc_i[3:2] : Opc_i[1:0];
                        AluDinA_o <= grant ? DinA_i[2*Width-1:Width] : DinA_i[Width-1:0];
                        AluDinB_o <= grant ? DinB_i[2*Width-1:Width] : DinB_i[Width-1:0];
                        RspId_o   <= grant;
                        Busy_o    <= 1'b1;
`ifdef ALU_ARB_RR_EN
                        last      <= grant;
`endif
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    // ALU output is only meaningful in this cycle.
                    RspDout_o     <= AluDout_i;
                    RspOverFlow_o <= AluOverFlow_i;
                    RspValid_o    <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (RspReady_i) begin
                        RspValid_o <= 1'b0;
                        Busy_o     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
